zero_padding_frame_arbiter: RTL

//  Frame-level round-robin arbiter sharing one zero_padding_axis engine among NUM_CH AXI-Stream feature-map channels.

---
 rtl/zero_padding_frame_arbiter_if.sv | 30 +++
 rtl/zero_padding_frame_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/zero_padding_frame_arbiter_if.sv
// zero_padding_frame_arbiter_if: AXI-Stream bundle between NUM_CH sources, the arbiter and the padder
//   s_axis_*   : NUM_CH source channels (tdata packed as channel i at [i*DATA_W +: DATA_W])
//   m00_axis_* : single stream towards the padder, tid carries the granted channel
//   slave      : arbiter view (consumes s_axis_*, produces m00_axis_*)
//   master     : environment view (produces s_axis_*, consumes m00_axis_*)
interface zero_padding_frame_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]        s_axis_tvalid;
    logic [NUM_CH-1:0]        s_axis_tready;
    logic [NUM_CH-1:0]        s_axis_tlast;
    logic [NUM_CH-1:0]        s_axis_tuser;
    logic [DATA_W-1:0]        m00_axis_tdata;
    logic                     m00_axis_tvalid;
    logic                     m00_axis_tready;
    logic                     m00_axis_tlast;
    logic                     m00_axis_tuser;
    logic [CH_W-1:0]          m00_axis_tid;
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m00_axis_tready,
        output s_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser, m00_axis_tid
    );
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m00_axis_tready,
        input  s_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser, m00_axis_tid
    );
endinterface

// File: rtl/zero_padding_frame_arbiter.sv
// zero_padding_frame_arbiter: frame-level round-robin arbiter feeding one zero_padding_axis engine
//   clk, reset : clock, asynchronous active-high reset
//   bus        : zero_padding_frame_arbiter_if.slave (NUM_CH sources in, m00 stream + tid out)
//   busy       : a frame is granted
//   frame_done : pulse on acceptance of the last beat of a frame
//   len_err    : pulse when tlast arrives at a beat count other than IMG_WIDTH
//   drop       : pulse when a pre-SOF beat is discarded while idle
//   timeout    : pulse on watchdog abort; only live when ZPAD_ARB_TIMEOUT_EN is defined
module zero_padding_frame_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int NUM_CH             = 4,
    parameter int IMG_WIDTH          = 640,
    parameter int IMG_HEIGHT         = 480,
    parameter int TIMEOUT_CYCLES     = 1024,
    localparam int CH_W              = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        reset,
    zero_padding_frame_arbiter_if.slave bus,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        len_err,
    output logic                        drop,
    output logic                        timeout
);
    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int PW = $clog2(IMG_WIDTH);
    localparam int LW = $clog2(IMG_HEIGHT);

    if (NUM_CH < 2 || NUM_CH > 16 || IMG_WIDTH < 2 || IMG_HEIGHT < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("zero_padding_frame_arbiter: illegal parameter set");
    end

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d, rr_q, rr_d, pick, idx, rr_next;
    logic [PW-1:0]     pix_q, pix_d;
    logic [LW-1:0]     line_q, line_d;
    logic [NUM_CH-1:0] req, junk;
    logic              found, xfer, g_valid, g_last, acc, eol, done, abort;

    assign xfer    = state_q == XFER;
    assign req     = bus.s_axis_tvalid & bus.s_axis_tuser;
    assign junk    = bus.s_axis_tvalid & ~bus.s_axis_tuser;
    assign g_valid = bus.s_axis_tvalid[grant_q];
    assign g_last  = bus.s_axis_tlast[grant_q];
    assign acc     = xfer & g_valid & bus.m00_axis_tready;
    assign eol     = acc & g_last;
    assign done    = eol & (line_q == LW'(IMG_HEIGHT - 1));
    assign rr_next = grant_q == CH_W'(NUM_CH - 1) ? '0 : grant_q + 1'b1;

    // Zero-latency pass-through of the granted channel; idle drives zeros except tid.
    assign bus.m00_axis_tvalid = xfer & g_valid;
    assign bus.m00_axis_tdata  = xfer ? bus.s_axis_tdata[int'(grant_q)*DW +: DW] : '0;
    assign bus.m00_axis_tlast  = xfer & g_last;
    assign bus.m00_axis_tuser  = xfer & bus.s_axis_tuser[grant_q];
    assign bus.m00_axis_tid    = grant_q;
    // Idle channels presenting non-SOF beats are drained so a fresh SOF can surface;
    // reset gates this so every output reads 0 while reset is held.
    assign bus.s_axis_tready   = reset ? '0 : xfer ? NUM_CH'(bus.m00_axis_tready) << grant_q : junk;

    assign busy       = xfer;
    assign frame_done = done;
    assign len_err    = eol & (pix_q != PW'(IMG_WIDTH - 1));
    assign drop       = ~reset & ~xfer & |junk;
    assign timeout    = abort;

    // Round-robin search: first requester at or after rr_q, wrapping.
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((int'(rr_q) + k) % NUM_CH);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

`ifdef ZPAD_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES);
    logic [SW-1:0] stall_q, stall_d;
    // Abort on the TIMEOUT_CYCLES-th consecutive cycle without a valid beat from the owner.
    assign abort   = xfer & ~g_valid & (stall_q == SW'(TIMEOUT_CYCLES - 1));
    assign stall_d = (!xfer || acc || abort) ? '0 : g_valid ? stall_q : stall_q + 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else stall_q <= stall_d;
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        pix_d   = pix_q;
        line_d  = line_q;
        if (!xfer) begin
            state_d = found ? XFER : IDLE;
            grant_d = found ? pick : grant_q;
            pix_d   = '0;
            line_d  = '0;
        end else if (done || abort) begin
            state_d = IDLE;
            rr_d    = rr_next;
            pix_d   = '0;
            line_d  = '0;
        end else if (acc) begin
            pix_d  = g_last ? '0 : pix_q + 1'b1;
            line_d = g_last ? line_q + 1'b1 : line_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            pix_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
        end
    end
endmodule
